reg_sweep_sched: RTL
====================

Name: reg_sweep_sched

Overview:
- Sequences register-file write sweeps: a sweep writes consecutive register numbers starting at a base, moving up or down for N steps.
- Shares the single register-file write port between the sweep engine and a direct single-write requester using 2-way round-robin arbitration.
- Sits between the lab control logic and the register file write port (wr_en / wr_regnum / wr_data).

Parameters:
DATA_W, 32, width of write data
LEN_W, 4, width of sweep length field (max 15 steps)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  sweep command offered
cmd_ready  out  1  sweep command accepted this cycle when cmd_valid&cmd_ready
cmd_base  in  5  first register number
cmd_len  in  LEN_W  number of writes; 0 = no-op
cmd_dir  in  1  1 = up (+1), 0 = down (-1)
cmd_data  in  DATA_W  data for first write; +1 per subsequent write
dir_valid  in  1  direct write request
dir_ready  out  1  direct write granted this cycle
dir_regnum  in  5  direct write register
dir_data  in  DATA_W  direct write data
wr_en  out  1  register-file write enable (registered)
wr_regnum  out  5  register-file write address (registered)
wr_data  out  DATA_W  register-file write data (registered)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at sweep completion
err  out  1  sweep hit register boundary; sticky until next cmd accept

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, wr_en=0, wr_regnum=0, wr_data=0, done=0, err=0, round-robin pointer = sweep-last (direct wins first contention).
- States: IDLE, SWEEP, DONE.
- IDLE: cmd_ready=1. On accept, latch base/len/dir/data and clear err.
  - len!=0 -> SWEEP.
  - len==0 -> DONE, with no writes.
- SWEEP: cmd_ready=0. Sweep request is active every cycle.
- Arbitration (combinational, per cycle):
  - Direct only: grant direct.
  - Sweep only: grant sweep.
  - Both: grant the requester not granted at the last contention; pointer updates only on contention cycles.
- dir_ready = direct grant. Direct writes are serviced in every state, including IDLE and DONE.
- Write latency: a grant in cycle N gives wr_en=1 with that regnum/data in cycle N+1. With no grant, wr_en=0 in N+1 and wr_regnum/wr_data hold.
- Sweep step on grant: write (cur_reg, cur_data), then cur_reg±1, cur_data+1, remaining-1.
  - The step with remaining==1 moves the FSM to DONE.
- DONE: done=1 for exactly one cycle, coinciding with wr_en of the final sweep write; then IDLE. A cmd is not accepted in DONE.
- Boundary (default): a step that writes reg 31 while up, or reg 0 while down, with remaining>1 ends the sweep after that write. It sets err=1 and goes to DONE.
- Reset mid-sweep: sweep abandoned, no done pulse, wr_en=0 the following cycle, IDLE.
- A cmd accepted and a direct grant in the same cycle are independent; both are allowed.

Optional Feature:
SWEEP_WRAP_EN
- Defined: register number wraps modulo 32 (31+1=0, 0-1=31); the sweep always completes all len writes; err is never set.
- Undefined: boundary termination with err as above.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE/SWEEP/DONE
  - REG_W=5
  - grant encodings GNT_NONE/GNT_SWEEP/GNT_DIR
- One natural sub-module, rr_arb2: 2-requester round-robin arbiter with a pointer register, reset to favour requester 1 (direct).

Test Plan:
- Up sweep: reset; cmd base=8 len=4 dir=1 data=0x100, no direct -> wr_en for 4 consecutive cycles with regnum 8,9,10,11 and data 0x100..0x103; done with the 4th write; busy drops the next cycle.
- Down sweep: cmd base=8 len=5 dir=0 data=0 -> regnum 8,7,6,5,4 with data 0..4; err=0.
- Contention: cmd base=9 len=3 up, dir_valid held with regnum=2 data=0xAA -> writes alternate direct, sweep, direct, sweep, direct, sweep; dir_ready high on direct-grant cycles only; done with the last sweep write.
- Boundary: cmd base=30 len=4 up -> default: writes 30,31, then done, err=1; with SWEEP_WRAP_EN: writes 30,31,0,1, err=0.
- Zero length: cmd len=0 -> no wr_en; done the cycle after accept; cmd_ready again the next cycle.
- Reset mid-sweep: cmd base=4 len=8 up, reset asserted after 3 writes -> wr_en=0 the next cycle, no done, busy=0, cmd_ready=1 once reset deasserts.

Source files
------------

// File: rtl/reg_sweep_sched_pkg.sv
// Shared types and helpers for the register-file sweep scheduler.
package reg_sweep_sched_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StDone  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GntNone  = 2'd0,
        GntSweep = 2'd1,
        GntDir   = 2'd2
    } gnt_e;

    // Register numbers wrap modulo 32 on their own; callers decide whether that is legal.
    function automatic logic [REG_W-1:0] next_reg(input logic [REG_W-1:0] r, input logic up);
        return up ? r + 1'b1 : r - 1'b1;
    endfunction

    function automatic logic at_edge(input logic [REG_W-1:0] r, input logic up);
        return up ? (r == '1) : (r == '0);
    endfunction

endpackage

// File: rtl/reg_sweep_sched_rr_arb2.sv
// Two-requester round-robin arbiter (sweep vs. direct write); the pointer moves only on contention.
module reg_sweep_sched_rr_arb2
    import reg_sweep_sched_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_sweep_i,
    input  logic req_dir_i,
    output gnt_e gnt_o
);

    // ptr_q = 1: direct wins the next contention.
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = GntNone;
        ptr_d = ptr_q;
        if (req_sweep_i && req_dir_i) begin
            gnt_o = ptr_q ? GntDir : GntSweep;
            ptr_d = ~ptr_q;
        end else if (req_dir_i) begin
            gnt_o = GntDir;
        end else if (req_sweep_i) begin
            gnt_o = GntSweep;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_sweep_sched.sv
// Register-file write sweep sequencer sharing the write port with direct writes.
// Define SWEEP_WRAP_EN to wrap register numbers instead of stopping at 0/31 with err.
module reg_sweep_sched
    import reg_sweep_sched_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [REG_W-1:0]  cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_dir,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              dir_valid,
    output logic              dir_ready,
    input  logic [REG_W-1:0]  dir_regnum,
    input  logic [DATA_W-1:0] dir_data,
    output logic              wr_en,
    output logic [REG_W-1:0]  wr_regnum,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e             state_q, state_d;
    logic [REG_W-1:0]   cur_reg_q, cur_reg_d;
    logic [DATA_W-1:0]  cur_data_q, cur_data_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               wr_en_q, wr_en_d;
    logic [REG_W-1:0]   wr_regnum_q, wr_regnum_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               cmd_acc;
    gnt_e               gnt;

    assign cmd_ready = (state_q == StIdle);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign dir_ready = (gnt == GntDir);

    reg_sweep_sched_rr_arb2 u_arb (
        .clock       (clock),
        .reset       (reset),
        .req_sweep_i (state_q == StSweep),
        .req_dir_i   (dir_valid),
        .gnt_o       (gnt)
    );

    always_comb begin
        state_d     = state_q;
        cur_reg_d   = cur_reg_q;
        cur_data_d  = cur_data_q;
        rem_d       = rem_q;
        dir_d       = dir_q;
        wr_en_d     = 1'b0;
        wr_regnum_d = wr_regnum_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;

        unique case (gnt)
            GntDir: begin
                wr_en_d     = 1'b1;
                wr_regnum_d = dir_regnum;
                wr_data_d   = dir_data;
            end
            GntSweep: begin
                wr_en_d     = 1'b1;
                wr_regnum_d = cur_reg_q;
                wr_data_d   = cur_data_q;
                cur_reg_d   = next_reg(cur_reg_q, dir_q);
                cur_data_d  = cur_data_q + 1'b1;
                rem_d       = rem_q - 1'b1;
            end
            default: ;
        endcase

        case (state_q)
            StIdle: begin
                if (cmd_acc) begin
                    cur_reg_d  = cmd_base;
                    cur_data_d = cmd_data;
                    rem_d      = cmd_len;
                    dir_d      = cmd_dir;
                    err_d      = 1'b0;
                    state_d    = (cmd_len == '0) ? StDone : StSweep;
                end
            end
            StSweep: begin
                if (gnt == GntSweep) begin
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
`ifndef SWEEP_WRAP_EN
                    // Walking off either end of the register file ends the sweep early.
                    else if (at_edge(cur_reg_q, dir_q)) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        done_d = (state_d == StDone);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_reg_q   <= '0;
            cur_data_q  <= '0;
            rem_q       <= '0;
            dir_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_regnum_q <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_reg_q   <= cur_reg_d;
            cur_data_q  <= cur_data_d;
            rem_q       <= rem_d;
            dir_q       <= dir_d;
            wr_en_q     <= wr_en_d;
            wr_regnum_q <= wr_regnum_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_regnum = wr_regnum_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;

endmodule
